// File: rtl/histogram_acc_if.sv
// Pixel-in / bin-out bundle for histogram_acc.
// slave modport is the accumulator side, master modport the pixel source / readout consumer.
// Control pulses and the pixel qualifier flow in; busy and the valid/ready bin stream flow out.
interface histogram_acc_if #(
   parameter int PIXEL_W  = 10,
   parameter int BIN_BITS = 10,
   parameter int COUNT_W  = 24
) ();
   logic                frame_start;
   logic [PIXEL_W-1:0]  pixel;
   logic                pixel_valid;
   logic                frame_end;
   logic                busy;
   logic                out_valid;
   logic                out_ready;
   logic [BIN_BITS-1:0] out_bin;
   logic [COUNT_W-1:0]  out_count;
   logic                out_last;
   logic                histo_done;

   modport slave (
      input  frame_start, pixel, pixel_valid, frame_end, out_ready,
      output busy, out_valid, out_bin, out_count, out_last, histo_done
   );

   modport master (
      output frame_start, pixel, pixel_valid, frame_end, out_ready,
      input  busy, out_valid, out_bin, out_count, out_last, histo_done
   );
endinterface

// File: rtl/histogram_acc.sv
// Per-frame pixel histogram: 2**BIN_BITS bins of COUNT_W-bit counters in a 1-cycle-latency RAM.
// Latency: pixel -> bin updated 1 cycle later (1 pixel/cycle); readout 1 bin per 2 cycles, first bin 2 cycles after READOUT entry.
// Backpressure: out_* held while out_valid && !out_ready; pixels are only taken in ACCUM (no stall on input).
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset (aborts everything, restarts CLEAR)
//   bus.slave     frame_start/frame_end pulses, pixel/pixel_valid input,
//                 busy, out_valid/out_ready/out_bin/out_count/out_last readout stream, histo_done pulse
//
// Build option: define HISTO_SATURATE_EN to make counters saturate at 2**COUNT_W-1 instead of wrapping.
module histogram_acc #(
   parameter int PIXEL_W  = 10,
   parameter int BIN_BITS = 10,
   parameter int COUNT_W  = 24
) (
   input  logic           clk,
   input  logic           rst,
   histogram_acc_if.slave bus
);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_ACCUM,
      S_DRAIN,
      S_READOUT
   } state_t;

   state_t state_q, state_d;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [BIN_BITS-1:0] clr_cnt_q,    clr_cnt_d;
   logic                drain_q,      drain_d;

   // stage 1 of the read-modify-write pipeline
   logic                s1_vld_q,     s1_vld_d;
   logic [BIN_BITS-1:0] s1_bin_q,     s1_bin_d;
   logic                s1_fwd_q,     s1_fwd_d;
   logic [COUNT_W-1:0]  s1_fwd_dat_q, s1_fwd_dat_d;

   // readout
   logic [BIN_BITS-1:0] ro_bin_q,     ro_bin_d;
   logic                rd_pend_q,    rd_pend_d;
   logic                out_vld_q,    out_vld_d;
   logic [COUNT_W-1:0]  out_cnt_q,    out_cnt_d;
   logic                done_q,       done_d;

   // bin RAM
   logic [COUNT_W-1:0]  mem_q [1<<BIN_BITS];
   logic [COUNT_W-1:0]  rdata_q;
   logic                ram_we;
   logic [BIN_BITS-1:0] ram_waddr;
   logic [COUNT_W-1:0]  ram_wdata;
   logic                ram_re;
   logic [BIN_BITS-1:0] ram_raddr;

   // ------------------------------------------------------------------
   // Shared combinational terms
   // ------------------------------------------------------------------
   logic [BIN_BITS-1:0] pix_bin;
   logic                accept_pix;
   logic                handshake;
   logic                ro_last;
   logic                ro_issue;
   logic [COUNT_W-1:0]  s1_cur;
   logic [COUNT_W-1:0]  s1_inc;
   logic                unused_pix;

   function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] v);
`ifdef HISTO_SATURATE_EN
      return (&v) ? v : v + COUNT_W'(1);
`else
      return v + COUNT_W'(1);
`endif
   endfunction

   // bin = pixel >> (PIXEL_W-BIN_BITS), i.e. the top BIN_BITS bits
   assign pix_bin    = bus.pixel[PIXEL_W-1 -: BIN_BITS];
   assign unused_pix = ^bus.pixel;

   assign accept_pix = (state_q == S_ACCUM) && bus.pixel_valid;
   assign handshake  = out_vld_q && bus.out_ready;
   assign ro_last    = &ro_bin_q;

   // A read issued while stage 1 was writing the same bin would return the
   // stale RAM word, so that case carries the written value along instead.
   assign s1_cur = s1_fwd_q ? s1_fwd_dat_q : rdata_q;
   assign s1_inc = bump(s1_cur);

   // Readout reads are issued once on READOUT entry (nothing pending, nothing
   // shown) and then together with each non-last handshake, which is what
   // gives the 2-cycle bin cadence.
   assign ro_issue = (state_q == S_READOUT) &&
                     ((!out_vld_q && !rd_pend_q) || (handshake && !ro_last));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR:   if (&clr_cnt_q)            state_d = S_IDLE;
         S_IDLE:    if (bus.frame_start)       state_d = S_ACCUM;
         S_ACCUM:   if (bus.frame_end)         state_d = S_DRAIN;
         S_DRAIN:   if (drain_q)               state_d = S_READOUT;
         S_READOUT: if (handshake && ro_last)  state_d = S_IDLE;
         default:                              state_d = S_CLEAR;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (RAM port control and busy)
   // ------------------------------------------------------------------
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      ram_re    = 1'b0;
      ram_raddr = '0;
      bus.busy  = (state_q != S_IDLE);

      case (state_q)
         S_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
         end
         S_READOUT: begin
            // clear-on-read: the bin just handed off is zeroed
            if (handshake) begin
               ram_we    = 1'b1;
               ram_waddr = ro_bin_q;
            end
         end
         default: begin
            // stage-1 write-back; only ever valid in ACCUM and the first DRAIN cycle
            if (s1_vld_q) begin
               ram_we    = 1'b1;
               ram_waddr = s1_bin_q;
               ram_wdata = s1_inc;
            end
         end
      endcase

      if (accept_pix) begin
         ram_re    = 1'b1;
         ram_raddr = pix_bin;
      end else if (ro_issue) begin
         ram_re    = 1'b1;
         ram_raddr = handshake ? ro_bin_q + BIN_BITS'(1) : ro_bin_q;
      end
   end

   // ------------------------------------------------------------------
   // Datapath next state
   // ------------------------------------------------------------------
   always_comb begin
      clr_cnt_d    = (state_q == S_CLEAR) ? clr_cnt_q + BIN_BITS'(1) : '0;
      drain_d      = (state_q == S_DRAIN) ? !drain_q : 1'b0;

      s1_vld_d     = accept_pix;
      s1_bin_d     = pix_bin;
      s1_fwd_d     = accept_pix && s1_vld_q && (s1_bin_q == pix_bin);
      s1_fwd_dat_d = s1_inc;

      ro_bin_d     = ro_bin_q;
      if (state_q != S_READOUT) begin
         ro_bin_d = '0;
      end else if (handshake) begin
         ro_bin_d = ro_bin_q + BIN_BITS'(1);
      end

      rd_pend_d    = ro_issue;

      out_vld_d    = out_vld_q;
      if (handshake) begin
         out_vld_d = 1'b0;
      end
      if (rd_pend_q) begin
         out_vld_d = 1'b1;
      end

      out_cnt_d    = rd_pend_q ? rdata_q : out_cnt_q;
      done_d       = (state_q == S_READOUT) && handshake && ro_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt_q    <= '0;
         drain_q      <= 1'b0;
         s1_vld_q     <= 1'b0;
         s1_bin_q     <= '0;
         s1_fwd_q     <= 1'b0;
         s1_fwd_dat_q <= '0;
         ro_bin_q     <= '0;
         rd_pend_q    <= 1'b0;
         out_vld_q    <= 1'b0;
         out_cnt_q    <= '0;
         done_q       <= 1'b0;
      end else begin
         clr_cnt_q    <= clr_cnt_d;
         drain_q      <= drain_d;
         s1_vld_q     <= s1_vld_d;
         s1_bin_q     <= s1_bin_d;
         s1_fwd_q     <= s1_fwd_d;
         s1_fwd_dat_q <= s1_fwd_dat_d;
         ro_bin_q     <= ro_bin_d;
         rd_pend_q    <= rd_pend_d;
         out_vld_q    <= out_vld_d;
         out_cnt_q    <= out_cnt_d;
         done_q       <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // Bin RAM: one write port, one read port, read returns the pre-write word
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[ram_waddr] <= ram_wdata;
      end
      if (ram_re) begin
         rdata_q <= mem_q[ram_raddr];
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.out_valid  = out_vld_q;
   assign bus.out_bin    = ro_bin_q;
   assign bus.out_count  = out_cnt_q;
   assign bus.out_last   = out_vld_q & ro_last;
   assign bus.histo_done = done_q;

endmodule
